// File: rtl/rpi_frame_packer.sv
// Raspberry Pi 1-bit video capture: synchronises the raw sync/colour pins, windows
// the active picture and packs 8 pixels per byte into SRAM write requests.
module rpi_frame_packer #(
  parameter int   ADDR_W   = 18,
  parameter int   PIX_DIV  = 2,
  parameter int   H_BACK   = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   V_BACK   = 33,
  parameter int   V_ACTIVE = 480,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic              FPGA_clk,
  input  logic              rst,
  input  logic              capture_en,
  input  logic              rpi_h_sync,
  input  logic              rpi_v_sync,
  input  logic              rpi_color,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VBP    = 3'd1;
  localparam logic [2:0] S_HWAIT  = 3'd2;
  localparam logic [2:0] S_HBP    = 3'd3;
  localparam logic [2:0] S_ACTIVE = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  localparam int CW = 16;
  localparam logic [CW-1:0] V_BACK_LAST = CW'(V_BACK - 1);
  localparam logic [CW-1:0] H_BACK_LAST = CW'(H_BACK - 1);
  localparam logic [CW-1:0] H_LAST      = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] DIV_LAST    = CW'(PIX_DIV - 1);
  localparam logic [CW-1:0] V_LINES     = CW'(V_ACTIVE);
  // Bit order matches pin_vec: {colour, v_sync, h_sync}
  localparam logic [2:0] SYNC_IDLE = {1'b0, ~SYNC_POL, ~SYNC_POL};

  logic [2:0] pin_vec;
  logic [2:0] sync_vec;
  logic [1:0] sync_prev_reg;
  logic       h_edge, v_edge, color_s;

  assign pin_vec = {rpi_color, rpi_v_sync, rpi_h_sync};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg, stable_reg;
      always_ff @(posedge FPGA_clk) begin
        if (rst) begin
          meta_reg   <= SYNC_IDLE[gi];
          stable_reg <= SYNC_IDLE[gi];
        end else begin
          meta_reg   <= pin_vec[gi];
          stable_reg <= meta_reg;
        end
      end
      assign sync_vec[gi] = stable_reg;
    end
  endgenerate

  always_ff @(posedge FPGA_clk) begin
    if (rst) sync_prev_reg <= SYNC_IDLE[1:0];
    else     sync_prev_reg <= sync_vec[1:0];
  end

  assign h_edge  = (sync_vec[0] == SYNC_POL) && (sync_prev_reg[0] != SYNC_POL);
  assign v_edge  = (sync_vec[1] == SYNC_POL) && (sync_prev_reg[1] != SYNC_POL);
  assign color_s = sync_vec[2];

  logic [2:0]        state_reg;
  logic [CW-1:0]     cnt_reg, div_reg, pix_reg, line_reg;
  logic [7:0]        shift_reg;
  logic [ADDR_W-1:0] next_addr_reg, wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic              wr_valid_reg, busy_reg, frame_done_reg, overflow_reg;

  logic       in_frame, start_frame, stop_frame, sample, last_pix, byte_done;
  logic [7:0] byte_val;

  always_comb begin
    in_frame    = (state_reg == S_VBP) || (state_reg == S_HWAIT) ||
                  (state_reg == S_HBP) || (state_reg == S_ACTIVE);
    start_frame = v_edge && capture_en && (in_frame || (state_reg == S_IDLE));
    stop_frame  = v_edge && !capture_en && in_frame;
    sample      = (state_reg == S_ACTIVE) && (div_reg == '0);
    last_pix    = (pix_reg == H_LAST);
    byte_val    = shift_reg;
    byte_val[pix_reg[2:0]] = color_s;
    // A byte finishing on the same cycle as a frame abort belongs to the dead frame
    byte_done   = sample && ((pix_reg[2:0] == 3'd7) || last_pix) && !(v_edge && in_frame);
  end

  always_ff @(posedge FPGA_clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      div_reg        <= '0;
      pix_reg        <= '0;
      line_reg       <= '0;
      shift_reg      <= '0;
      next_addr_reg  <= '0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      wr_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (wr_valid_reg && wr_ready) wr_valid_reg <= 1'b0;

      if (byte_done) begin
        shift_reg <= '0;
        if (!wr_valid_reg || wr_ready) begin
          wr_valid_reg  <= 1'b1;
          wr_addr_reg   <= next_addr_reg;
          wr_data_reg   <= byte_val;
          next_addr_reg <= next_addr_reg + 1'b1;
        end else begin
          overflow_reg <= 1'b1;
        end
      end else if (sample) begin
        shift_reg <= byte_val;
      end

      if (start_frame) begin
        state_reg     <= S_VBP;
        busy_reg      <= 1'b1;
        overflow_reg  <= 1'b0;
        next_addr_reg <= '0;
        shift_reg     <= '0;
        cnt_reg       <= '0;
        line_reg      <= '0;
      end else if (stop_frame) begin
        state_reg <= S_DRAIN;
      end else begin
        case (state_reg)
          S_VBP: begin
            if (V_BACK == 0) begin
              state_reg <= S_HWAIT;
            end else if (h_edge) begin
              if (cnt_reg == V_BACK_LAST) begin
                state_reg <= (H_BACK == 0) ? S_ACTIVE : S_HBP;
                cnt_reg   <= '0;
                div_reg   <= '0;
                pix_reg   <= '0;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end
          S_HWAIT: begin
            if (h_edge) begin
              state_reg <= (H_BACK == 0) ? S_ACTIVE : S_HBP;
              cnt_reg   <= '0;
              div_reg   <= '0;
              pix_reg   <= '0;
            end
          end
          S_HBP: begin
            if (cnt_reg == H_BACK_LAST) state_reg <= S_ACTIVE;
            else                        cnt_reg   <= cnt_reg + 1'b1;
          end
          S_ACTIVE: begin
            div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
            if (sample && last_pix) begin
              line_reg  <= line_reg + 1'b1;
              state_reg <= (line_reg + 1'b1 == V_LINES) ? S_DRAIN : S_HWAIT;
            end else if (sample) begin
              pix_reg <= pix_reg + 1'b1;
            end
          end
          S_DRAIN: begin
            if (!wr_valid_reg) begin
              frame_done_reg <= 1'b1;
              busy_reg       <= 1'b0;
              state_reg      <= S_IDLE;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign wr_valid   = wr_valid_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;
endmodule

// File: tb/tb_rpi_frame_packer.sv
// Scoreboard bench for rpi_frame_packer: a 16-pixel/18-bit-address unit plus a
// 12-pixel/3-bit-address unit sharing the same video pins.
module tb_rpi_frame_packer;
  localparam int HB = 4;
  localparam int PD = 2;
  localparam int VB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, capture_en, h_sync, v_sync, color, ready0, ready1;
  logic        valid0, busy0, done0, ovf0;
  logic [17:0] addr0;
  logic [7:0]  data0;
  logic        valid1, busy1, done1, ovf1;
  logic [2:0]  addr1;
  logic [7:0]  data1;

  int total = 0;
  int bad   = 0;
  int acc0  = 0;
  int done_cnt = 0;
  logic [25:0] exp_q[$];
  logic [10:0] got1_q[$];
  logic [17:0] exp_addr;

  rpi_frame_packer #(.ADDR_W(18), .PIX_DIV(PD), .H_BACK(HB), .H_ACTIVE(16),
                     .V_BACK(VB), .V_ACTIVE(2), .SYNC_POL(1'b1)) dut0 (
    .FPGA_clk(clk), .rst(rst), .capture_en(capture_en),
    .rpi_h_sync(h_sync), .rpi_v_sync(v_sync), .rpi_color(color),
    .wr_valid(valid0), .wr_ready(ready0), .wr_addr(addr0), .wr_data(data0),
    .busy(busy0), .frame_done(done0), .overflow(ovf0)
  );

  rpi_frame_packer #(.ADDR_W(3), .PIX_DIV(PD), .H_BACK(HB), .H_ACTIVE(12),
                     .V_BACK(VB), .V_ACTIVE(8), .SYNC_POL(1'b1)) dut1 (
    .FPGA_clk(clk), .rst(rst), .capture_en(capture_en),
    .rpi_h_sync(h_sync), .rpi_v_sync(v_sync), .rpi_color(color),
    .wr_valid(valid1), .wr_ready(ready1), .wr_addr(addr1), .wr_data(data1),
    .busy(busy1), .frame_done(done1), .overflow(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // While a request is pending it must match the scoreboard head on every cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (valid0) begin
        if (exp_q.size() == 0) begin
          chk("wr_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("wr", {6'd0, addr0, data0}, {6'd0, exp_q[0]});
          if (ready0) void'(exp_q.pop_front());
        end
        if (ready0) acc0++;
      end
      if (done0) done_cnt++;
      if (valid1 && ready1) got1_q.push_back({addr1, data1});
    end
  end

  // mode 0: normal, 1: stall wr_ready for 20 cycles, 2: vsync abort with pending byte
  task automatic send_line(input logic [15:0] pix, input bit cap, input int mode);
    tick(1); h_sync = 1'b1;
    tick(2); h_sync = 1'b0;
    tick(HB - 2);
    for (int k = 0; k < 16; k++) begin
      color = pix[k];
      if (cap && k == 7) begin
        exp_q.push_back({exp_addr, pix[7:0]});
        exp_addr++;
      end
      if (cap && k == 15 && mode == 0) begin
        exp_q.push_back({exp_addr, pix[15:8]});
        exp_addr++;
      end
      if (mode == 1 && k == 8) begin
        fork
          begin
            ready0 = 1'b0;
            tick(20);
            ready0 = 1'b1;
          end
        join_none
      end
      if (mode == 2 && k == 9) begin
        ready0 = 1'b0;
        v_sync = 1'b1;
      end
      if (mode == 2 && k == 11) v_sync = 1'b0;
      if (mode == 2 && k == 12) ready0 = 1'b1;
      tick(PD);
    end
    color = 1'b0;
    tick(12);
  endtask

  task automatic frame_start();
    tick(1); v_sync = 1'b1;
    tick(3); v_sync = 1'b0;
    tick(10);
    exp_addr = '0;
    for (int i = 0; i < VB - 1; i++) send_line(16'h0000, 1'b0, 0);
  endtask

  initial begin
    logic [10:0] e1;
    int acc_before;
    rst = 1'b1; capture_en = 1'b0; h_sync = 1'b0; v_sync = 1'b0; color = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1; exp_addr = '0;
    tick(5);
    rst = 1'b0;
    tick(2);
    chk("rst_valid", valid0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 0);
    chk("rst_valid1", valid1, 0);

    // Frame A: alternating 1,0 -> 0x55 at addresses 0..3
    capture_en = 1'b1;
    frame_start();
    chk("a_busy_on", busy0, 1);
    send_line(16'h5555, 1'b1, 0);
    send_line(16'h5555, 1'b1, 0);
    tick(20);
    chk("a_done", done_cnt, 1);
    chk("a_ovf", ovf0, 0);
    chk("a_busy_off", busy0, 0);
    chk("a_left", exp_q.size(), 0);

    // Frame B: stall during line 0 -> second byte dropped, overflow sticky
    frame_start();
    send_line(16'($urandom), 1'b1, 1);
    send_line(16'($urandom), 1'b1, 0);
    tick(20);
    chk("b_ovf", ovf0, 1);
    chk("b_done", done_cnt, 2);
    chk("b_left", exp_q.size(), 0);

    // Frame C: vsync mid line 1 with a pending byte, then restart from addr 0
    frame_start();
    chk("c_ovf_clr", ovf0, 0);
    send_line(16'($urandom), 1'b1, 0);
    send_line(16'($urandom), 1'b1, 2);
    chk("c_busy_restart", busy0, 1);
    chk("c_no_done", done_cnt, 2);
    exp_addr = '0;
    for (int i = 0; i < VB - 1; i++) send_line(16'h0000, 1'b0, 0);
    send_line(16'($urandom), 1'b1, 0);
    send_line(16'($urandom), 1'b1, 0);
    tick(20);
    chk("c_done", done_cnt, 3);
    chk("c_left", exp_q.size(), 0);

    // Frame D: capture disabled at frame start -> nothing written
    capture_en = 1'b0;
    acc_before = acc0;
    frame_start();
    chk("d_busy", busy0, 0);
    send_line(16'($urandom), 1'b0, 0);
    send_line(16'($urandom), 1'b0, 0);
    tick(20);
    chk("d_acc", acc0 - acc_before, 0);
    chk("d_done", done_cnt, 3);
    chk("d_busy1", busy1, 0);

    // Frame E: constant white, 8 lines; the 3-bit unit wraps 0..7,0..7
    capture_en = 1'b1;
    got1_q.delete();
    frame_start();
    for (int i = 0; i < 8; i++) send_line(16'hFFFF, (i < 2), 0);
    tick(20);
    chk("e_done", done_cnt, 4);
    chk("e_left", exp_q.size(), 0);
    chk("e1_count", got1_q.size(), 16);
    for (int i = 0; i < 16 && i < got1_q.size(); i++) begin
      e1 = {3'(i), ((i % 2) == 0) ? 8'hFF : 8'h0F};
      chk("e1_wr", got1_q[i], e1);
    end
    chk("e1_busy", busy1, 0);
    chk("e1_ovf", ovf1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
